// File: rtl/x_memarb_if.sv
// Requester-side and main-port signal bundle for the x_memarb round-robin memory arbiter.
// The slave modport is the arbiter's view; master is the environment (requesters plus crossbar).
interface x_memarb_if #(
    parameter int NREQ = 4
);
    logic [NREQ-1:0]      i_req_valid;
    logic [NREQ-1:0]      o_req_accept;
    logic [NREQ-1:0]      i_req_rd_n_wr;
    logic [19*NREQ-1:0]   i_req_addr;
    logic [8*NREQ-1:0]    i_req_wdata;
    logic [NREQ-1:0]      o_req_ready;
    logic [7:0]           o_req_rdata;
    logic                 o_req_err;
    logic                 o_main_valid;
    logic                 i_main_accept;
    logic                 o_main_rd_n_wr;
    logic [18:0]          o_main_addr;
    logic [7:0]           o_main_wdata;
    logic                 i_main_ready;
    logic [7:0]           i_main_rdata;

    modport slave (
        input  i_req_valid, i_req_rd_n_wr, i_req_addr, i_req_wdata,
        input  i_main_accept, i_main_ready, i_main_rdata,
        output o_req_accept, o_req_ready, o_req_rdata, o_req_err,
        output o_main_valid, o_main_rd_n_wr, o_main_addr, o_main_wdata
    );

    modport master (
        output i_req_valid, i_req_rd_n_wr, i_req_addr, i_req_wdata,
        output i_main_accept, i_main_ready, i_main_rdata,
        input  o_req_accept, o_req_ready, o_req_rdata, o_req_err,
        input  o_main_valid, o_main_rd_n_wr, o_main_addr, o_main_wdata
    );
endinterface

// File: rtl/x_memarb.sv
// Round-robin arbiter sharing one 19-bit main memory port between NREQ requesters,
// one outstanding transaction at a time, with a response watchdog.
module x_memarb #(
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 1023
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    x_memarb_if.slave     bus,
    output logic          o_busy,
    output logic [2:0]    o_grant
);
    localparam int WDW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [WDW-1:0] WD_LIMIT = WDW'(TIMEOUT);
    localparam logic [2:0]     LAST_REQ = 3'(NREQ - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nx_s;
    logic [2:0]       rr_ptr_r;
    logic [2:0]       grant_r;
    logic [WDW-1:0]   wd_r;
    logic             main_valid_r;
    logic             main_rd_n_wr_r;
    logic [18:0]      main_addr_r;
    logic [7:0]       main_wdata_r;

    logic             any_req_s;
    logic [2:0]       pick_s;
    logic [NREQ-1:0]  grant_oh_s;
    logic             wd_expired_s;
    logic             complete_s;
    logic             timeout_s;

    // Lowest set bit at or above ptr; falls back to the lowest set bit overall (wrap).
    function automatic logic [2:0] rr_pick(input logic [NREQ-1:0] vld, input logic [2:0] ptr);
        logic [NREQ-1:0] lo_mask;
        logic [NREQ-1:0] hi;
        logic [NREQ-1:0] src;
        logic [NREQ-1:0] tmp;
        logic [2:0]      sel;
        lo_mask = (NREQ'(1) << ptr) - NREQ'(1);
        hi      = vld & ~lo_mask;
        src     = (hi != '0) ? hi : vld;
        sel     = 3'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            tmp = src >> i;
            if (tmp[0]) begin
                sel = 3'(i);
            end
        end
        return sel;
    endfunction

    assign any_req_s    = (bus.i_req_valid != '0);
    assign pick_s       = rr_pick(bus.i_req_valid, rr_ptr_r);
    assign grant_oh_s   = NREQ'(1) << grant_r;
    assign wd_expired_s = (wd_r == WD_LIMIT);

    // Completion detection: ready taken with accept in REQ, or ready/watchdog expiry in WAIT.
    always_comb begin
        complete_s = 1'b0;
        timeout_s  = 1'b0;
        case (state_r)
            ST_REQ: begin
                complete_s = bus.i_main_accept & bus.i_main_ready;
            end
            ST_WAIT: begin
                complete_s = bus.i_main_ready | wd_expired_s;
                timeout_s  = ~bus.i_main_ready & wd_expired_s;
            end
            default: begin
                complete_s = 1'b0;
                timeout_s  = 1'b0;
            end
        endcase
    end

    // Next-state logic.
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (any_req_s) state_nx_s = ST_REQ;
                else           state_nx_s = ST_IDLE;
            end
            ST_REQ: begin
                if (bus.i_main_accept) state_nx_s = complete_s ? ST_IDLE : ST_WAIT;
                else                   state_nx_s = ST_REQ;
            end
            ST_WAIT: begin
                if (complete_s) state_nx_s = ST_IDLE;
                else            state_nx_s = ST_WAIT;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Requester-facing responses; read data is forced to zero unless a real completion is shown.
    always_comb begin
        bus.o_req_accept = '0;
        bus.o_req_ready  = '0;
        bus.o_req_rdata  = 8'h00;
        bus.o_req_err    = 1'b0;
        if ((state_r == ST_REQ) && bus.i_main_accept) begin
            bus.o_req_accept = grant_oh_s;
        end else begin
            bus.o_req_accept = '0;
        end
        if (complete_s) begin
            bus.o_req_ready = grant_oh_s;
            bus.o_req_err   = timeout_s;
            bus.o_req_rdata = timeout_s ? 8'h00 : bus.i_main_rdata;
        end else begin
            bus.o_req_ready = '0;
        end
    end

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_r <= ST_IDLE;
        else          state_r <= state_nx_s;
    end

    // Grant, round-robin pointer, watchdog and registered main-port fields.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            rr_ptr_r       <= 3'd0;
            grant_r        <= 3'd0;
            wd_r           <= '0;
            main_valid_r   <= 1'b0;
            main_rd_n_wr_r <= 1'b1;
            main_addr_r    <= 19'd0;
            main_wdata_r   <= 8'd0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (any_req_s) begin
                        grant_r        <= pick_s;
                        main_valid_r   <= 1'b1;
                        main_rd_n_wr_r <= 1'((bus.i_req_rd_n_wr >> pick_s));
                        main_addr_r    <= 19'((bus.i_req_addr >> (32'd19 * {29'd0, pick_s})));
                        main_wdata_r   <= 8'((bus.i_req_wdata >> (32'd8 * {29'd0, pick_s})));
                    end
                end
                ST_REQ: begin
                    if (bus.i_main_accept) begin
                        main_valid_r <= 1'b0;
                        wd_r         <= '0;
                    end
                end
                ST_WAIT: begin
                    if (!wd_expired_s) wd_r <= wd_r + WDW'(1);
                end
                default: begin
                    main_valid_r <= 1'b0;
                end
            endcase
            if (complete_s) begin
                rr_ptr_r <= (grant_r == LAST_REQ) ? 3'd0 : grant_r + 3'd1;
            end
        end
    end

    assign bus.o_main_valid   = main_valid_r;
    assign bus.o_main_rd_n_wr = main_rd_n_wr_r;
    assign bus.o_main_addr    = main_addr_r;
    assign bus.o_main_wdata   = main_wdata_r;
    assign o_busy             = (state_r != ST_IDLE);
    assign o_grant            = grant_r;
endmodule

// File: tb/tb_x_memarb.sv
// Directed self-checking bench for x_memarb (NREQ=4, TIMEOUT=8).
module tb_x_memarb;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       busy;
    logic [2:0] grant;
    int         n_checks = 0;
    int         n_fail   = 0;

    always #5 clk = ~clk;

    x_memarb_if #(.NREQ(4)) bus ();

    x_memarb #(.NREQ(4), .TIMEOUT(8)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus.slave),
        .o_busy  (busy),
        .o_grant (grant)
    );

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic next_cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic sample;
        @(negedge clk);
    endtask

    // One transaction from an IDLE cycle: accept on first REQ cycle, ready on first WAIT cycle.
    task automatic do_txn(input int g, input logic [7:0] rd);
        bus.i_main_accept = 1'b0;
        bus.i_main_ready  = 1'b0;
        sample;
        check("txn_idle_busy", 32'(busy), 32'd0);
        next_cyc;
        bus.i_main_accept = 1'b1;
        sample;
        check("txn_grant", 32'(grant), 32'(g));
        check("txn_accept", 32'(bus.o_req_accept), 32'(4'b0001 << g));
        next_cyc;
        bus.i_main_accept = 1'b0;
        bus.i_main_ready  = 1'b1;
        bus.i_main_rdata  = rd;
        sample;
        check("txn_ready", 32'(bus.o_req_ready), 32'(4'b0001 << g));
        check("txn_rdata", 32'(bus.o_req_rdata), 32'(rd));
        next_cyc;
        bus.i_main_ready = 1'b0;
        bus.i_main_rdata = 8'h00;
    endtask

    initial begin
        rst_n             = 1'b0;
        bus.i_req_valid   = 4'b0000;
        bus.i_req_rd_n_wr = 4'b1111;
        bus.i_req_addr    = '0;
        bus.i_req_wdata   = '0;
        bus.i_main_accept = 1'b0;
        bus.i_main_ready  = 1'b0;
        bus.i_main_rdata  = 8'h00;
        repeat (2) @(posedge clk);
        sample;
        check("rst_main_valid", 32'(bus.o_main_valid), 32'd0);
        check("rst_rd_n_wr", 32'(bus.o_main_rd_n_wr), 32'd1);
        check("rst_addr", 32'(bus.o_main_addr), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_grant", 32'(grant), 32'd0);
        next_cyc;
        rst_n = 1'b1;

        // Single read from requester 2.
        next_cyc;
        bus.i_req_valid = 4'b0100;
        bus.i_req_addr[2*19 +: 19] = 19'h12345;
        sample;
        check("rd_pre_valid", 32'(bus.o_main_valid), 32'd0);
        next_cyc;
        bus.i_main_ready = 1'b1;
        sample;
        check("rd_main_valid", 32'(bus.o_main_valid), 32'd1);
        check("rd_main_addr", 32'(bus.o_main_addr), 32'h12345);
        check("rd_main_rnw", 32'(bus.o_main_rd_n_wr), 32'd1);
        check("rd_grant", 32'(grant), 32'd2);
        check("rd_no_accept", 32'(bus.o_req_accept), 32'd0);
        check("rd_ready_in_req_ignored", 32'(bus.o_req_ready), 32'd0);
        next_cyc;
        bus.i_main_ready  = 1'b0;
        bus.i_main_accept = 1'b1;
        sample;
        check("rd_accept", 32'(bus.o_req_accept), 32'h4);
        next_cyc;
        bus.i_main_accept = 1'b0;
        bus.i_req_valid   = 4'b0000;
        sample;
        check("rd_wait_valid", 32'(bus.o_main_valid), 32'd0);
        check("rd_wait_busy", 32'(busy), 32'd1);
        next_cyc;
        next_cyc;
        bus.i_main_ready = 1'b1;
        bus.i_main_rdata = 8'hA5;
        sample;
        check("rd_ready", 32'(bus.o_req_ready), 32'h4);
        check("rd_rdata", 32'(bus.o_req_rdata), 32'hA5);
        check("rd_err", 32'(bus.o_req_err), 32'd0);
        next_cyc;
        bus.i_main_ready = 1'b0;
        sample;
        check("rd_done_busy", 32'(busy), 32'd0);
        check("rd_done_rdata", 32'(bus.o_req_rdata), 32'd0);

        // Round-robin from a fresh pointer: expect 0,1,2,3,0,1.
        rst_n = 1'b0;
        next_cyc;
        rst_n = 1'b1;
        bus.i_req_valid = 4'b1111;
        for (int i = 0; i < 6; i++) begin
            do_txn(i % 4, 8'(8'h10 + i));
        end

        // Pointer wrap: pointer is now 2; serve 3, then 0 ahead of 3.
        bus.i_req_valid = 4'b1000;
        do_txn(3, 8'h33);
        bus.i_req_valid = 4'b1001;
        do_txn(0, 8'h44);
        bus.i_req_valid = 4'b1000;
        do_txn(3, 8'h55);

        // Ready together with accept (pointer now 0, requester 1 only).
        bus.i_req_valid = 4'b0010;
        sample;
        next_cyc;
        bus.i_main_accept = 1'b1;
        bus.i_main_ready  = 1'b1;
        bus.i_main_rdata  = 8'h3C;
        sample;
        check("rwa_accept", 32'(bus.o_req_accept), 32'h2);
        check("rwa_ready", 32'(bus.o_req_ready), 32'h2);
        check("rwa_rdata", 32'(bus.o_req_rdata), 32'h3C);
        check("rwa_err", 32'(bus.o_req_err), 32'd0);
        next_cyc;
        bus.i_main_accept = 1'b0;
        bus.i_main_ready  = 1'b0;
        bus.i_main_rdata  = 8'h00;
        bus.i_req_valid   = 4'b0000;
        sample;
        check("rwa_idle_busy", 32'(busy), 32'd0);
        check("rwa_idle_valid", 32'(bus.o_main_valid), 32'd0);

        // Timeout: pointer 2, requesters 2 and 0 valid; requester 2 hangs.
        bus.i_req_valid = 4'b0101;
        next_cyc;
        bus.i_main_accept = 1'b1;
        sample;
        check("to_grant", 32'(grant), 32'd2);
        next_cyc;
        bus.i_main_accept = 1'b0;
        bus.i_req_valid   = 4'b0001;
        bus.i_main_rdata  = 8'hFF;
        for (int w = 0; w < 8; w++) begin
            sample;
            check("to_no_ready_early", 32'(bus.o_req_ready), 32'd0);
            next_cyc;
        end
        sample;
        check("to_ready", 32'(bus.o_req_ready), 32'h4);
        check("to_err", 32'(bus.o_req_err), 32'd1);
        check("to_rdata_zero", 32'(bus.o_req_rdata), 32'd0);
        next_cyc;
        bus.i_main_rdata = 8'h00;
        do_txn(0, 8'h66);
        bus.i_req_valid = 4'b0000;

        // Reset in the middle of WAIT (pointer now 1).
        bus.i_req_valid = 4'b0010;
        next_cyc;
        bus.i_main_accept = 1'b1;
        next_cyc;
        bus.i_main_accept = 1'b0;
        bus.i_req_valid   = 4'b0000;
        sample;
        check("rmw_busy_before", 32'(busy), 32'd1);
        next_cyc;
        rst_n = 1'b0;
        #1;
        check("rmw_main_valid", 32'(bus.o_main_valid), 32'd0);
        check("rmw_busy", 32'(busy), 32'd0);
        check("rmw_grant", 32'(grant), 32'd0);
        bus.i_main_ready = 1'b1;
        sample;
        check("rmw_ready_in_reset", 32'(bus.o_req_ready), 32'd0);
        next_cyc;
        rst_n = 1'b1;
        sample;
        check("rmw_late_ready", 32'(bus.o_req_ready), 32'd0);
        check("rmw_addr", 32'(bus.o_main_addr), 32'd0);
        next_cyc;
        bus.i_main_ready = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
